// File: rtl/int_ctrl_pkg.sv
// Shared constants for the interrupt controller: source bit positions,
// register addresses and the dispatch state encoding.
package int_ctrl_pkg;

  localparam int NUM_IRQ    = 5;
  localparam int IRQ_VBLANK = 0;
  localparam int IRQ_STAT   = 1;
  localparam int IRQ_TIMER  = 2;
  localparam int IRQ_SERIAL = 3;
  localparam int IRQ_JOYPAD = 4;

  localparam logic [15:0] IF_ADDR_DEF = 16'hFF0F;
  localparam logic [15:0] IE_ADDR_DEF = 16'hFFFF;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_DISPATCH = 1'b1
  } state_e;

endpackage

// File: rtl/int_ctrl_if.sv
// CPU-side bus and control-unit handshake of the interrupt controller.
// master = CPU/control unit, slave = int_ctrl.
interface int_ctrl_if;
  logic [15:0] addr;
  logic [7:0]  wr_data;
  logic        wr_en;
  logic [7:0]  rd_data;
  logic        rd_hit;
  logic        ei;
  logic        di;
  logic        reti;
  logic        instr_done;
  logic        int_ack;
  logic        int_done;
  logic        int_req;
  logic [2:0]  int_pc_out;
  logic        ime;
  logic        wake;

  modport master (
    output addr, wr_data, wr_en, ei, di, reti, instr_done, int_ack, int_done,
    input  rd_data, rd_hit, int_req, int_pc_out, ime, wake
  );

  modport slave (
    input  addr, wr_data, wr_en, ei, di, reti, instr_done, int_ack, int_done,
    output rd_data, rd_hit, int_req, int_pc_out, ime, wake
  );
endinterface

// File: rtl/int_prio_enc.sv
// Fixed-priority encoder: index of the lowest set pending bit (VBlank first).
module int_prio_enc
  import int_ctrl_pkg::*;
(
  input  logic [NUM_IRQ-1:0] pending_i,
  output logic [2:0]         index_o,
  output logic               any_valid_o
);

  always_comb begin
    index_o = 3'd0;
    // Scan downwards so the lowest set bit is the last to be written.
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (pending_i[i]) index_o = 3'(i);
    end
    any_valid_o = |pending_i;
  end

endmodule

// File: rtl/int_ctrl.sv
// Game Boy interrupt controller: IF/IE/IME registers, priority arbitration
// and the request/ack/done dispatch handshake with the control unit.
module int_ctrl
  import int_ctrl_pkg::*;
#(
  parameter logic [15:0] IF_ADDR = IF_ADDR_DEF,
  parameter logic [15:0] IE_ADDR = IE_ADDR_DEF
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] irq_in,
  int_ctrl_if.slave          bus
);

  logic [NUM_IRQ-1:0] if_q, if_d;
  logic [7:0]         ie_q, ie_d;
  logic               ime_q, ime_d;
  logic               ei_pend_q, ei_pend_d;
  state_e             state_q, state_d;
  logic [2:0]         pc_q, pc_d;

  logic [NUM_IRQ-1:0] pending;
  logic [2:0]         prio_idx;
  logic               prio_any;
  logic               int_req;
  logic               dispatch;
  logic               if_hit, ie_hit;

  assign if_hit  = (bus.addr == IF_ADDR);
  assign ie_hit  = (bus.addr == IE_ADDR);
  assign pending = ie_q[NUM_IRQ-1:0] & if_q;

  int_prio_enc u_prio_enc (
    .pending_i   (pending),
    .index_o     (prio_idx),
    .any_valid_o (prio_any)
  );

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    int_req  = 1'b0;
    dispatch = 1'b0;
    case (state_q)
      ST_IDLE: begin
        int_req = ime_q & prio_any;
        if (int_req && bus.int_ack) begin
          dispatch = 1'b1;
          pc_d     = prio_idx;
          state_d  = ST_DISPATCH;
        end
      end
      ST_DISPATCH: begin
        if (bus.int_done) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Peripheral set wins over both a CPU write and the dispatch clear.
  for (genvar gi = 0; gi < NUM_IRQ; gi++) begin : g_if_bit
    logic base_bit;
    assign base_bit   = (bus.wr_en && if_hit) ? bus.wr_data[gi] : if_q[gi];
    assign if_d[gi]   = irq_in[gi] |
                        (base_bit & ~(dispatch && (prio_idx == 3'(gi))));
  end

  assign ie_d = (bus.wr_en && ie_hit) ? bus.wr_data : ie_q;

  always_comb begin
    ime_d     = ime_q;
    ei_pend_d = ei_pend_q;
    // A pending EI takes effect only at a later instruction boundary.
    if (bus.instr_done && ei_pend_q && !bus.ei) begin
      ime_d     = 1'b1;
      ei_pend_d = 1'b0;
    end
    if (bus.ei) ei_pend_d = 1'b1;
    if (bus.reti) begin
      ime_d     = 1'b1;
      ei_pend_d = 1'b0;
    end
    if (bus.di || dispatch) begin
      ime_d     = 1'b0;
      ei_pend_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      if_q      <= '0;
      ie_q      <= '0;
      ime_q     <= 1'b0;
      ei_pend_q <= 1'b0;
      state_q   <= ST_IDLE;
      pc_q      <= 3'd0;
    end else begin
      if_q      <= if_d;
      ie_q      <= ie_d;
      ime_q     <= ime_d;
      ei_pend_q <= ei_pend_d;
      state_q   <= state_d;
      pc_q      <= pc_d;
    end
  end

  always_comb begin
    bus.rd_data = 8'h00;
    if (if_hit)      bus.rd_data = {3'b111, if_q};
    else if (ie_hit) bus.rd_data = ie_q;
  end

  assign bus.rd_hit     = if_hit | ie_hit;
  assign bus.int_req    = int_req;
  assign bus.int_pc_out = pc_q;
  assign bus.ime        = ime_q;
  assign bus.wake       = |pending;

endmodule
